// File: rtl/mem_hs_pkg.sv
// Shared definitions for the valid/ready single-port memory handshake.
//
// Contents:
//   DEF_WIDTH, DEF_ADDR_WIDTH : default word and address widths, shared with
//                               the `memory` responder so both ends agree.
//   DIR_WR / DIR_RD           : encoding of the wr_rd direction bit.
//   state_e                   : burst initiator FSM states.
package mem_hs_pkg;

  localparam int DEF_WIDTH      = 16;
  localparam int DEF_ADDR_WIDTH = 4;

  localparam logic DIR_WR = 1'b1;
  localparam logic DIR_RD = 1'b0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    REQ   = 2'd2,
    DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/mem_hs_timeout.sv
// Loadable down-counter used as a per-beat handshake watchdog.
//
// Ports:
//   clk_i       : clock, all logic on posedge.
//   rst_ni      : asynchronous active-low reset, counter returns to 0.
//   clr_i       : synchronous clear to 0 (highest priority).
//   load_i      : load load_val_i (next priority).
//   load_val_i  : cycle budget to load.
//   en_i        : count one waiting cycle.
//   expired_o   : high in the enabled cycle that consumes the last unit of
//                 budget, so the owner can abort on the same clock edge.
module mem_hs_timeout #(
  parameter int CNT_WIDTH = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 clr_i,
  input  logic                 load_i,
  input  logic [CNT_WIDTH-1:0] load_val_i,
  input  logic                 en_i,
  output logic                 expired_o
);

  logic [CNT_WIDTH-1:0] count_q;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of every other flop, independent of block ordering.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else if (clr_i) begin
      count_q <= '0;
    end else if (load_i) begin
      count_q <= load_val_i;
    end else if (en_i && (count_q != '0)) begin
      count_q <= count_q - 1'b1;
    end
  end

  assign expired_o = en_i && (count_q == CNT_WIDTH'(1));

endmodule

// File: rtl/mem_burst_initiator.sv
// Initiator side of the valid/ready single-port memory handshake. Issues a
// burst of len_i consecutive word writes or reads starting at base_addr_i.
// Write data is pulled from an upstream valid/ready stream; read data is
// pushed downstream as one-cycle rd_valid_o pulses without backpressure.
//
// Ports:
//   clk_i, rst_ni                 : clock and asynchronous active-low reset.
//   start_i, cmd_wr_i,
//   base_addr_i, len_i            : command, sampled only in IDLE.
//   busy_o, done_o, err_o         : burst status; err_o is a sticky timeout
//                                   flag cleared by the next accepted start.
//   wdata_i, wdata_valid_i,
//   wdata_ready_o                 : upstream write-data stream.
//   rd_data_o, rd_valid_o         : downstream read-data stream.
//   addr_o, wdata_o, wr_rd_o,
//   valid_o, ready_i, rdata_i     : memory request channel.
module mem_burst_initiator
  import mem_hs_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int TIMEOUT    = 64
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  start_i,
  input  logic                  cmd_wr_i,
  input  logic [ADDR_WIDTH-1:0] base_addr_i,
  input  logic [ADDR_WIDTH:0]   len_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  err_o,
  input  logic [WIDTH-1:0]      wdata_i,
  input  logic                  wdata_valid_i,
  output logic                  wdata_ready_o,
  output logic [WIDTH-1:0]      rd_data_o,
  output logic                  rd_valid_o,
  output logic [ADDR_WIDTH-1:0] addr_o,
  output logic [WIDTH-1:0]      wdata_o,
  output logic                  wr_rd_o,
  output logic                  valid_o,
  input  logic                  ready_i,
  input  logic [WIDTH-1:0]      rdata_i
);

  localparam int TO_W = $clog2(TIMEOUT + 1);
  localparam logic [ADDR_WIDTH:0] LAST_BEAT = (ADDR_WIDTH + 1)'(1);

  state_e                state_q;
  logic [ADDR_WIDTH:0]   remain_q;   // beats still to transfer
  logic                  to_load;
  logic                  to_en;
  logic                  to_clr;
  logic                  to_expired;

  // The watchdog budget restarts whenever REQ is (re)entered and on every
  // transfer, so it bounds the wait for each individual beat.
  // NOTE: every signal written in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    to_load = 1'b0;
    case (state_q)
      IDLE:    to_load = start_i && (len_i != '0) && (cmd_wr_i == DIR_RD);
      FETCH:   to_load = wdata_valid_i;
      REQ:     to_load = ready_i;
      default: to_load = 1'b0;
    endcase
  end

  assign to_en  = (state_q == REQ) && !ready_i;
  assign to_clr = (state_q == DONE);

  mem_hs_timeout #(
    .CNT_WIDTH (TO_W)
  ) u_timeout (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .clr_i      (to_clr),
    .load_i     (to_load),
    .load_val_i (TO_W'(TIMEOUT)),
    .en_i       (to_en),
    .expired_o  (to_expired)
  );

  // Single FSM with registered outputs. wr_rd_o doubles as the latched
  // command direction and addr_o as the running address.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= IDLE;
      remain_q      <= '0;
      busy_o        <= 1'b0;
      done_o        <= 1'b0;
      err_o         <= 1'b0;
      wdata_ready_o <= 1'b0;
      rd_data_o     <= '0;
      rd_valid_o    <= 1'b0;
      addr_o        <= '0;
      wdata_o       <= '0;
      wr_rd_o       <= 1'b0;
      valid_o       <= 1'b0;
    end else begin
      // Pulse outputs default low and are raised only where they fire.
      done_o     <= 1'b0;
      rd_valid_o <= 1'b0;

      case (state_q)
        IDLE: begin
          if (start_i) begin
            busy_o   <= 1'b1;
            err_o    <= 1'b0;
            wr_rd_o  <= cmd_wr_i;
            addr_o   <= base_addr_i;
            remain_q <= len_i;
            if (len_i == '0) begin
              state_q <= DONE;
            end else if (cmd_wr_i == DIR_WR) begin
              wdata_ready_o <= 1'b1;
              state_q       <= FETCH;
            end else begin
              valid_o <= 1'b1;
              state_q <= REQ;
            end
          end
        end

        FETCH: begin
          // wdata_ready_o is high throughout FETCH, so valid alone completes
          // the upstream handshake. No watchdog here: the source may idle.
          if (wdata_valid_i) begin
            wdata_o       <= wdata_i;
            wdata_ready_o <= 1'b0;
            valid_o       <= 1'b1;
            state_q       <= REQ;
          end
        end

        REQ: begin
          if (ready_i) begin
            addr_o   <= addr_o + 1'b1;  // wraps modulo the memory depth
            remain_q <= remain_q - 1'b1;
            if (wr_rd_o == DIR_RD) begin
              rd_data_o  <= rdata_i;
              rd_valid_o <= 1'b1;
            end
            if (remain_q == LAST_BEAT) begin
              valid_o <= 1'b0;
              state_q <= DONE;
            end else if (wr_rd_o == DIR_WR) begin
              valid_o       <= 1'b0;
              wdata_ready_o <= 1'b1;
              state_q       <= FETCH;
            end
            // Reads stay in REQ with valid_o held for back-to-back beats.
          end else if (to_expired) begin
            // Abort: remaining beats are discarded.
            err_o   <= 1'b1;
            valid_o <= 1'b0;
            state_q <= DONE;
          end
        end

        DONE: begin
          done_o  <= 1'b1;
          busy_o  <= 1'b0;
          state_q <= IDLE;
        end

        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_burst_initiator.sv
// Self-checking bench for mem_burst_initiator. A scoreboard predicts every
// memory transfer (address, direction, data) from the burst command alone;
// a behavioural responder memory answers requests and is compared against
// the predicted memory image at the end.
module tb_mem_burst_initiator;

  localparam int WIDTH   = 16;
  localparam int AW      = 4;
  localparam int LW      = AW + 1;
  localparam int DEPTH   = 16;
  localparam int TIMEOUT = 64;

  localparam int R_ALWAYS = 0;
  localparam int R_NEVER  = 1;
  localparam int R_RAND   = 2;
  localparam int R_AFTER1 = 3;

  logic             clk_i = 1'b0;
  logic             rst_ni = 1'b0;
  logic             start_i = 1'b0;
  logic             cmd_wr_i = 1'b0;
  logic [AW-1:0]    base_addr_i = '0;
  logic [LW-1:0]    len_i = '0;
  logic             busy_o, done_o, err_o;
  logic [WIDTH-1:0] wdata_i = '0;
  logic             wdata_valid_i = 1'b0;
  logic             wdata_ready_o;
  logic [WIDTH-1:0] rd_data_o;
  logic             rd_valid_o;
  logic [AW-1:0]    addr_o;
  logic [WIDTH-1:0] wdata_o;
  logic             wr_rd_o;
  logic             valid_o;
  logic             ready_i = 1'b0;
  logic [WIDTH-1:0] rdata_i = '0;

  always #5 clk_i = ~clk_i;

  mem_burst_initiator #(
    .WIDTH      (WIDTH),
    .ADDR_WIDTH (AW),
    .TIMEOUT    (TIMEOUT)
  ) dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .start_i       (start_i),
    .cmd_wr_i      (cmd_wr_i),
    .base_addr_i   (base_addr_i),
    .len_i         (len_i),
    .busy_o        (busy_o),
    .done_o        (done_o),
    .err_o         (err_o),
    .wdata_i       (wdata_i),
    .wdata_valid_i (wdata_valid_i),
    .wdata_ready_o (wdata_ready_o),
    .rd_data_o     (rd_data_o),
    .rd_valid_o    (rd_valid_o),
    .addr_o        (addr_o),
    .wdata_o       (wdata_o),
    .wr_rd_o       (wr_rd_o),
    .valid_o       (valid_o),
    .ready_i       (ready_i),
    .rdata_i       (rdata_i)
  );

  typedef struct packed {
    logic [AW-1:0]    addr;
    logic             wr;
    logic [WIDTH-1:0] data;
  } beat_t;

  int               total = 0;
  int               bad   = 0;
  beat_t            exp_q[$];
  logic [WIDTH-1:0] stream_q[$];
  logic [WIDTH-1:0] exp_mem[DEPTH];
  logic [WIDTH-1:0] resp_mem[DEPTH];
  int               rmode = R_ALWAYS;
  int               wprob = 100;
  int               waitc = 0;
  bit               exp_to = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_ctrl"}, {busy_o, done_o, err_o, valid_o, wdata_ready_o,
                           rd_valid_o, wr_rd_o, addr_o}, 0);
    check({tag, "_wdata"}, wdata_o, 0);
    check({tag, "_rdata"}, rd_data_o, 0);
  endtask

  // Responder and upstream source, driven once per cycle after the negedge.
  task automatic drive_inputs();
    case (rmode)
      R_ALWAYS: ready_i = 1'b1;
      R_NEVER:  ready_i = 1'b0;
      R_RAND:   ready_i = ($urandom_range(0, 99) < 55);
      default:  ready_i = valid_o && (waitc >= 1);
    endcase
    if (valid_o && !ready_i) waitc++;
    else waitc = 0;
    rdata_i = ready_i ? resp_mem[addr_o] : WIDTH'($urandom);
    if (stream_q.size() > 0 && $urandom_range(0, 99) < wprob) begin
      wdata_valid_i = 1'b1;
      wdata_i       = stream_q[0];
    end else begin
      wdata_valid_i = 1'b0;
      wdata_i       = WIDTH'($urandom);
    end
  endtask

  // Advance one clock; score what happened on that edge, then drive.
  task automatic tick();
    logic             pv, pr, pw, pwr, pwv;
    logic [AW-1:0]    pa;
    logic [WIDTH-1:0] pd;
    beat_t            b;
    pv = valid_o; pr = ready_i; pw = wr_rd_o; pa = addr_o; pd = wdata_o;
    pwr = wdata_ready_o; pwv = wdata_valid_i;
    @(negedge clk_i);
    if (pwr && pwv && stream_q.size() > 0) void'(stream_q.pop_front());
    if (pv && pr) begin
      if (pw) resp_mem[pa] = pd;
      check("xfer_expected", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        b = exp_q.pop_front();
        check("xfer_addr", pa, b.addr);
        check("xfer_dir", pw, b.wr);
        if (b.wr) begin
          check("xfer_wdata", pd, b.data);
        end else begin
          check("rd_valid", rd_valid_o, 1);
          check("rd_data", rd_data_o, b.data);
        end
      end
    end else begin
      check("rd_valid_idle", rd_valid_o, 0);
      if (pv) begin
        check("stall_addr", addr_o, pa);
        check("stall_wdata", wdata_o, pd);
        check("stall_dir", wr_rd_o, pw);
        if (!exp_to) check("stall_valid", valid_o, 1);
      end
    end
    drive_inputs();
  endtask

  // Reference model: a burst touches (base+i) mod DEPTH for i in 0..len-1.
  task automatic plan_burst(input bit wr, input int base, input int len,
                            input bit to, input bit data_inc);
    int               a;
    logic [WIDTH-1:0] d;
    beat_t            b;
    for (int i = 0; i < len; i++) begin
      a = (base + i) % DEPTH;
      if (wr) begin
        d = data_inc ? WIDTH'(32'h1000 + i) : WIDTH'($urandom);
        stream_q.push_back(d);
        exp_mem[a] = d;
      end else begin
        d = exp_mem[a];
      end
      if (!to) begin
        b.addr = AW'(a); b.wr = wr; b.data = d;
        exp_q.push_back(b);
      end
    end
  endtask

  task automatic run_burst(input bit wr, input int base, input int len, input int rm,
                           input int wp, input bit to, input bit spur, input bit data_inc,
                           output int cycles, output int vcnt);
    bit seen;
    rmode = rm; wprob = wp; exp_to = to; waitc = 0;
    plan_burst(wr, base, len, to, data_inc);
    drive_inputs();
    start_i = 1'b1; cmd_wr_i = wr; base_addr_i = AW'(base); len_i = LW'(len);
    tick();
    start_i = 1'b0; cmd_wr_i = 1'($urandom); base_addr_i = AW'($urandom);
    len_i = LW'($urandom_range(1, 16));
    check("busy_after_start", busy_o, 1);
    check("err_cleared", err_o, 0);
    if (len > 0 && !wr) check("first_valid", valid_o, 1);
    if (len > 0 && wr) check("first_fetch", wdata_ready_o, 1);
    cycles = 1; vcnt = int'(valid_o); seen = 1'b0;
    while (!seen && cycles < 2000) begin
      start_i = 1'b0;
      if (spur && busy_o && $urandom_range(0, 7) == 0) begin
        start_i = 1'b1; cmd_wr_i = 1'($urandom); base_addr_i = AW'($urandom);
        len_i = LW'($urandom_range(1, 16));
      end
      tick();
      cycles++;
      if (valid_o) vcnt++;
      if (done_o) seen = 1'b1;
    end
    start_i = 1'b0;
    check("done_seen", seen, 1);
    check("xfers_left", exp_q.size(), 0);
    if (wr) check("stream_left", stream_q.size(), 0);
    check("busy_at_done", busy_o, 0);
    check("err_at_done", err_o, to);
    check("valid_at_done", valid_o, 0);
    tick();
    check("done_one_cycle", done_o, 0);
    check("err_sticky", err_o, to);
  endtask

  initial begin
    int cyc, vc;
    for (int i = 0; i < DEPTH; i++) begin
      exp_mem[i]  = '0;
      resp_mem[i] = '0;
    end
    repeat (2) @(negedge clk_i);
    check_zero("reset");
    rst_ni = 1'b1;
    drive_inputs();
    tick();
    check_zero("idle");

    // Full write then read-back with data 0x1000+i.
    run_burst(1'b1, 0, 16, R_AFTER1, 100, 1'b0, 1'b0, 1'b1, cyc, vc);
    run_burst(1'b0, 0, 16, R_ALWAYS, 100, 1'b0, 1'b0, 1'b0, cyc, vc);
    check("rd16_cycles", cyc, 18);
    check("rd16_valid_cycles", vc, 16);

    // Address wrap: 14, 15, 0, 1.
    run_burst(1'b1, 14, 4, R_RAND, 60, 1'b0, 1'b0, 1'b0, cyc, vc);
    run_burst(1'b0, 14, 4, R_RAND, 60, 1'b0, 1'b0, 1'b0, cyc, vc);

    // Timeout on a read that the responder never accepts.
    run_burst(1'b0, 5, 3, R_NEVER, 100, 1'b1, 1'b0, 1'b0, cyc, vc);
    check("timeout_valid_cycles", vc, TIMEOUT);
    run_burst(1'b0, 2, 2, R_ALWAYS, 100, 1'b0, 1'b0, 1'b0, cyc, vc);

    // Zero-length commands.
    run_burst(1'b0, 3, 0, R_ALWAYS, 100, 1'b0, 1'b0, 1'b0, cyc, vc);
    check("len0_rd_cycles", cyc, 2);
    check("len0_rd_valid", vc, 0);
    run_burst(1'b1, 3, 0, R_ALWAYS, 100, 1'b0, 1'b0, 1'b0, cyc, vc);
    check("len0_wr_cycles", cyc, 2);
    check("len0_wr_valid", vc, 0);

    // Random stalls, source gaps and ignored starts.
    for (int k = 0; k < 8; k++) begin
      run_burst(1'($urandom), $urandom_range(0, 15), $urandom_range(1, 16),
                R_RAND, 50, 1'b0, 1'b1, 1'b0, cyc, vc);
    end
    run_burst(1'b1, 7, 16, R_RAND, 50, 1'b0, 1'b1, 1'b0, cyc, vc);
    run_burst(1'b0, 7, 16, R_RAND, 50, 1'b0, 1'b1, 1'b0, cyc, vc);

    for (int i = 0; i < DEPTH; i++) check("mem_match", resp_mem[i], exp_mem[i]);

    // Asynchronous reset in the middle of a read burst.
    rmode = R_ALWAYS; exp_to = 1'b0; waitc = 0;
    plan_burst(1'b0, 9, 8, 1'b0, 1'b0);
    drive_inputs();
    start_i = 1'b1; cmd_wr_i = 1'b0; base_addr_i = AW'(9); len_i = LW'(8);
    tick();
    start_i = 1'b0;
    repeat (4) tick();
    check("pre_reset_busy", busy_o, 1);
    #2 rst_ni = 1'b0;
    #1 check_zero("async_reset");
    exp_q.delete();
    repeat (2) begin
      @(negedge clk_i);
      check("reset_no_done", done_o, 0);
    end
    rst_ni = 1'b1;
    repeat (3) begin
      @(negedge clk_i);
      check("post_reset_no_done", {done_o, busy_o, valid_o}, 0);
    end
    drive_inputs();
    run_burst(1'b0, 9, 3, R_ALWAYS, 100, 1'b0, 1'b0, 1'b0, cyc, vc);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
